id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and bubble insertion.
//  Latches decoded operands and control from decode.
//  Drives the execute-stage E_* bus: E_Rs, E_Rt, E_ALUSrc, the E_RegWr/E_Rw pair, data and ALU control.
//  The forwarding unit and the execute-stage ALU muxes consume that bus.
//  Stalls IF/ID when a load in EX feeds the instruction in decode; counts inserted bubbles.
// PARAMETERS
//  DW   32  datapath width (PC, bus, immediate)
//  CW   16  bubble-counter width (saturating)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   reset, asynchronous, active-low
//  D_PC        in   DW  decode-stage PC
//  D_BusA      in   DW  register-file read A
//  D_BusB      in   DW  register-file read B
//  D_Imm32     in   DW  extended immediate
//  D_Rs        in   5   decode source register Rs
//  D_Rt        in   5   decode source register Rt
//  D_Rd        in   5   decode destination field Rd
//  D_UsesRt    in   1   decode instruction reads Rt as a source
//  D_RegDst    in   1   1: dest=Rd, 0: dest=Rt
//  D_RegWr     in   1   decode register write enable
//  D_ALUSrc    in   1   ALU operand B = immediate
//  D_ALUCtr    in   4   ALU operation
//  D_MemWr     in   1   store
//  D_MemToReg  in   1   load (writeback from memory)
//  Hold        in   1   global freeze (memory wait)
//  Flush       in   1   squash decode instruction (taken branch/jump)
//  E_PC, E_BusA, E_BusB, E_Imm32  out  DW  registered data
//  E_Rs, E_Rt, E_Rw               out  5   registered register numbers; E_Rw is the resolved destination
//  E_RegWr, E_ALUSrc, E_MemWr, E_MemToReg  out  1  registered control
//  E_ALUCtr    out  4   registered ALU operation
//  E_Valid     out  1   EX holds a real instruction (0 = bubble)
//  Stall       out  1   freeze PC and IF/ID this cycle
//  BubbleCnt   out  CW  load-use bubbles inserted since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): all E_* outputs, E_Valid and BubbleCnt are 0.
//   Stall therefore reads 0; state recovers on the first clk edge after release.
//  Destination: E_Rw <= D_RegDst ? D_Rd : D_Rt, resolved at capture.
//  LoadUse (combinational from registered EX state) is asserted when all hold:
//   E_Valid & E_MemToReg & E_RegWr & (E_Rw != 0)
//   & (E_Rw == D_Rs | (D_UsesRt & E_Rw == D_Rt)).
//  Stall = Hold | (LoadUse & ~Flush).
//  Per rising edge, priority order:
//   1 Hold=1: all E_* and BubbleCnt keep their value; Flush/LoadUse ignored.
//     The source of Flush keeps it high until Hold drops.
//   2 Flush=1: load NOP (all control 0, E_Valid=0); data/reg fields don't-care (load 0).
//   3 LoadUse=1: load NOP; BubbleCnt += 1, saturating at all-ones (no wrap).
//   4 else: capture all D_* into E_*, E_Valid <= 1.
//  A NOP never writes, so E_RegWr=0 and downstream forwarding cannot match it.
//  E_ALUSrc=0 in a NOP.
//  Latency: one cycle D->E. Bubble: exactly one cycle per load-use.
//   The stalled instruction is re-presented and captured on the next edge,
//   since the bubble clears LoadUse.
//  Register 0 is never a hazard source.
//  A back-to-back dependent load chain yields one bubble per pair.
//  Hold asserted mid-bubble: the bubble persists until Hold drops; no double count.
// STRUCTURE
//  Shared package pipe_pkg holds:
//   DW, REG_W=5, ALUCTR_W=4, the e_ctrl_t struct {RegWr, ALUSrc, ALUCtr, MemWr, MemToReg}
//   and constant CTRL_NOP.
//  One sub-module, load_use_det: purely combinational LoadUse compare.
//  The register bank and the counter live in id_ex_stage.
// TESTING
//  1 Reset: rst_n=0 mid-stream, asynchronous -> all E_* =0, E_Valid=0, Stall=0, BubbleCnt=0
//    within the same cycle, before the next clk.
//  2 Load-use on Rs: lw to $8, then add with Rs=$8.
//    -> Stall=1 one cycle, one NOP (E_Valid=0), BubbleCnt=1; add captured next cycle.
//  3 No hazard cases, each -> no stall, BubbleCnt unchanged:
//    lw to $0 followed by a reader of $0;
//    lw to $9 followed by an ori with Rt=$9 and D_UsesRt=0.
//  4 Flush with LoadUse:
//    -> NOP loaded, Stall=0, BubbleCnt unchanged.
//    Flush alone with valid decode -> E_Valid=0 next cycle.
//  5 Hold for 3 cycles during LoadUse:
//    -> E_* frozen, Stall=1 throughout, BubbleCnt increments once after release.
//  6 Saturation: CW=2, 5 load-use pairs -> BubbleCnt reads 3 after the third, stays 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, execute-stage control bundle,
// and the per-edge action chosen by the ID/EX register.
package pipe_pkg;

    localparam int DW       = 32;
    localparam int REG_W    = 5;
    localparam int ALUCTR_W = 4;

    // Control fields that travel with an instruction into execute
    typedef struct packed {
        logic                RegWr;
        logic                ALUSrc;
        logic [ALUCTR_W-1:0] ALUCtr;
        logic                MemWr;
        logic                MemToReg;
    } e_ctrl_t;

    // A bubble: never writes, never touches memory, ALU operand B from the bus
    localparam e_ctrl_t CTRL_NOP = '0;

    // What the ID/EX register does on a given rising edge
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_FLUSH   = 2'd2,
        ACT_HOLD    = 2'd3
    } ex_action_e;

    // Destination register chosen by the RegDst control bit
    function automatic logic [REG_W-1:0] resolve_dest(
        input logic             reg_dst,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rt
    );
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX pipeline register.
// master = decode/control side driving D_*, Hold, Flush; slave = the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DW = pipe_pkg::DW
);

    logic [DW-1:0]                  D_PC;
    logic [DW-1:0]                  D_BusA;
    logic [DW-1:0]                  D_BusB;
    logic [DW-1:0]                  D_Imm32;
    logic [pipe_pkg::REG_W-1:0]     D_Rs;
    logic [pipe_pkg::REG_W-1:0]     D_Rt;
    logic [pipe_pkg::REG_W-1:0]     D_Rd;
    logic                           D_UsesRt;
    logic                           D_RegDst;
    logic                           D_RegWr;
    logic                           D_ALUSrc;
    logic [pipe_pkg::ALUCTR_W-1:0]  D_ALUCtr;
    logic                           D_MemWr;
    logic                           D_MemToReg;
    logic                           Hold;
    logic                           Flush;

    logic [DW-1:0]                  E_PC;
    logic [DW-1:0]                  E_BusA;
    logic [DW-1:0]                  E_BusB;
    logic [DW-1:0]                  E_Imm32;
    logic [pipe_pkg::REG_W-1:0]     E_Rs;
    logic [pipe_pkg::REG_W-1:0]     E_Rt;
    logic [pipe_pkg::REG_W-1:0]     E_Rw;
    logic                           E_RegWr;
    logic                           E_ALUSrc;
    logic                           E_MemWr;
    logic                           E_MemToReg;
    logic [pipe_pkg::ALUCTR_W-1:0]  E_ALUCtr;
    logic                           E_Valid;
    logic                           Stall;

    modport master (
        output D_PC, D_BusA, D_BusB, D_Imm32, D_Rs, D_Rt, D_Rd,
               D_UsesRt, D_RegDst, D_RegWr, D_ALUSrc, D_ALUCtr,
               D_MemWr, D_MemToReg, Hold, Flush,
        input  E_PC, E_BusA, E_BusB, E_Imm32, E_Rs, E_Rt, E_Rw,
               E_RegWr, E_ALUSrc, E_MemWr, E_MemToReg, E_ALUCtr,
               E_Valid, Stall
    );

    modport slave (
        input  D_PC, D_BusA, D_BusB, D_Imm32, D_Rs, D_Rt, D_Rd,
               D_UsesRt, D_RegDst, D_RegWr, D_ALUSrc, D_ALUCtr,
               D_MemWr, D_MemToReg, Hold, Flush,
        output E_PC, E_BusA, E_BusB, E_Imm32, E_Rs, E_Rt, E_Rw,
               E_RegWr, E_ALUSrc, E_MemWr, E_MemToReg, E_ALUCtr,
               E_Valid, Stall
    );

endinterface

// File: rtl/id_ex_stage_load_use_det.sv
// Load-use hazard compare: a valid load in EX whose destination is read
// by the instruction currently in decode. Register 0 never counts.
module load_use_det import pipe_pkg::*; (
    input  logic             e_valid,
    input  logic             e_reg_wr,
    input  logic             e_mem_to_reg,
    input  logic [REG_W-1:0] e_rw,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_uses_rt,
    output logic             load_use
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // Flag a hazard only for a real, writing load targeting a non-zero register
    always_comb begin
        ex_is_load = e_valid & e_mem_to_reg & e_reg_wr & (e_rw != '0);
        rs_match   = (e_rw == d_rs);
        rt_match   = d_uses_rt & (e_rw == d_rt);
        load_use   = ex_is_load & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of inserted bubbles.
module id_ex_stage import pipe_pkg::*; #(
    parameter int DW = pipe_pkg::DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus,
    output logic [CW-1:0] BubbleCnt
);

    logic [DW-1:0]    e_pc_q,    e_pc_d;
    logic [DW-1:0]    e_bus_a_q, e_bus_a_d;
    logic [DW-1:0]    e_bus_b_q, e_bus_b_d;
    logic [DW-1:0]    e_imm_q,   e_imm_d;
    logic [REG_W-1:0] e_rs_q,    e_rs_d;
    logic [REG_W-1:0] e_rt_q,    e_rt_d;
    logic [REG_W-1:0] e_rw_q,    e_rw_d;
    e_ctrl_t          e_ctrl_q,  e_ctrl_d;
    logic             e_valid_q, e_valid_d;
    logic [CW-1:0]    bubble_cnt_q, bubble_cnt_d;

    e_ctrl_t          d_ctrl;
    logic             load_use;
    ex_action_e       action;

    load_use_det u_load_use_det (
        .e_valid      (e_valid_q),
        .e_reg_wr     (e_ctrl_q.RegWr),
        .e_mem_to_reg (e_ctrl_q.MemToReg),
        .e_rw         (e_rw_q),
        .d_rs         (bus.D_Rs),
        .d_rt         (bus.D_Rt),
        .d_uses_rt    (bus.D_UsesRt),
        .load_use     (load_use)
    );

    // Bundle decode control and pick this edge's action: freeze, squash, bubble, capture
    always_comb begin
        d_ctrl.RegWr    = bus.D_RegWr;
        d_ctrl.ALUSrc   = bus.D_ALUSrc;
        d_ctrl.ALUCtr   = bus.D_ALUCtr;
        d_ctrl.MemWr    = bus.D_MemWr;
        d_ctrl.MemToReg = bus.D_MemToReg;
        action = ACT_CAPTURE;
        if (bus.Hold) begin
            action = ACT_HOLD;
        end else if (bus.Flush) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_BUBBLE;
        end
    end

    // Next EX contents: keep under Hold, NOP on squash/bubble, else take decode
    always_comb begin
        e_pc_d       = e_pc_q;
        e_bus_a_d    = e_bus_a_q;
        e_bus_b_d    = e_bus_b_q;
        e_imm_d      = e_imm_q;
        e_rs_d       = e_rs_q;
        e_rt_d       = e_rt_q;
        e_rw_d       = e_rw_q;
        e_ctrl_d     = e_ctrl_q;
        e_valid_d    = e_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        case (action)
            ACT_HOLD: begin
            end
            ACT_FLUSH, ACT_BUBBLE: begin
                e_pc_d    = '0;
                e_bus_a_d = '0;
                e_bus_b_d = '0;
                e_imm_d   = '0;
                e_rs_d    = '0;
                e_rt_d    = '0;
                e_rw_d    = '0;
                e_ctrl_d  = CTRL_NOP;
                e_valid_d = 1'b0;
                if ((action == ACT_BUBBLE) && (bubble_cnt_q != '1)) begin
                    bubble_cnt_d = bubble_cnt_q + CW'(1);
                end
            end
            ACT_CAPTURE: begin
                e_pc_d    = bus.D_PC;
                e_bus_a_d = bus.D_BusA;
                e_bus_b_d = bus.D_BusB;
                e_imm_d   = bus.D_Imm32;
                e_rs_d    = bus.D_Rs;
                e_rt_d    = bus.D_Rt;
                e_rw_d    = resolve_dest(bus.D_RegDst, bus.D_Rd, bus.D_Rt);
                e_ctrl_d  = d_ctrl;
                e_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ID/EX register bank and bubble counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_pc_q       <= '0;
            e_bus_a_q    <= '0;
            e_bus_b_q    <= '0;
            e_imm_q      <= '0;
            e_rs_q       <= '0;
            e_rt_q       <= '0;
            e_rw_q       <= '0;
            e_ctrl_q     <= CTRL_NOP;
            e_valid_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            e_pc_q       <= e_pc_d;
            e_bus_a_q    <= e_bus_a_d;
            e_bus_b_q    <= e_bus_b_d;
            e_imm_q      <= e_imm_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_rw_q       <= e_rw_d;
            e_ctrl_q     <= e_ctrl_d;
            e_valid_q    <= e_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.E_PC       = e_pc_q;
    assign bus.E_BusA     = e_bus_a_q;
    assign bus.E_BusB     = e_bus_b_q;
    assign bus.E_Imm32    = e_imm_q;
    assign bus.E_Rs       = e_rs_q;
    assign bus.E_Rt       = e_rt_q;
    assign bus.E_Rw       = e_rw_q;
    assign bus.E_RegWr    = e_ctrl_q.RegWr;
    assign bus.E_ALUSrc   = e_ctrl_q.ALUSrc;
    assign bus.E_ALUCtr   = e_ctrl_q.ALUCtr;
    assign bus.E_MemWr    = e_ctrl_q.MemWr;
    assign bus.E_MemToReg = e_ctrl_q.MemToReg;
    assign bus.E_Valid    = e_valid_q;
    assign bus.Stall      = bus.Hold | (load_use & ~bus.Flush);
    assign BubbleCnt      = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for the ID/EX stage: directed hazard scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int BUBBLE_MAX = (1 << CW) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        bit          uses_rt;
        bit          reg_dst;
        bit          reg_wr;
        bit          alu_src;
        logic [3:0]  alu_ctr;
        bit          mem_wr;
        bit          mem_to_reg;
    } instr_t;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        bit          reg_wr;
        bit          alu_src;
        logic [3:0]  alu_ctr;
        bit          mem_wr;
        bit          mem_to_reg;
        int          bubbles;
    } ex_state_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    ex_state_t model;
    bit        stall_q[$];
    ex_state_t state_q[$];

    id_ex_stage_if #(.DW(DW)) bus ();

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .BubbleCnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expectation and tally the result
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input bit uses_rt, input bit reg_dst, input bit reg_wr,
                                  input bit alu_src, input logic [3:0] alu_ctr,
                                  input bit mem_wr, input bit mem_to_reg);
        instr_t i;
        i.pc = $urandom; i.bus_a = $urandom; i.bus_b = $urandom; i.imm = $urandom;
        i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = uses_rt; i.reg_dst = reg_dst;
        i.reg_wr = reg_wr; i.alu_src = alu_src; i.alu_ctr = alu_ctr;
        i.mem_wr = mem_wr; i.mem_to_reg = mem_to_reg;
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] rt);
        return mk(5'd29, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
    endfunction

    function automatic instr_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return mk(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    endfunction

    function automatic instr_t ori(input logic [4:0] rs, input logic [4:0] rt);
        return mk(rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    endfunction

    function automatic instr_t rand_instr();
        return mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom));
    endfunction

    task automatic driveInputs(input instr_t ins, input bit hold, input bit flush);
        bus.D_PC = ins.pc;         bus.D_BusA = ins.bus_a;
        bus.D_BusB = ins.bus_b;    bus.D_Imm32 = ins.imm;
        bus.D_Rs = ins.rs;         bus.D_Rt = ins.rt;          bus.D_Rd = ins.rd;
        bus.D_UsesRt = ins.uses_rt; bus.D_RegDst = ins.reg_dst; bus.D_RegWr = ins.reg_wr;
        bus.D_ALUSrc = ins.alu_src; bus.D_ALUCtr = ins.alu_ctr;
        bus.D_MemWr = ins.mem_wr;  bus.D_MemToReg = ins.mem_to_reg;
        bus.Hold = hold;           bus.Flush = flush;
    endtask

    // Present one decode slot, predict the stall and the EX contents after the edge
    task automatic applyStimulus(input instr_t ins, input bit hold, input bit flush, output bit stalled);
        bit hazard;
        driveInputs(ins, hold, flush);
        hazard = model.valid && model.mem_to_reg && model.reg_wr && (model.rw != 5'd0) &&
                 ((model.rw == ins.rs) || (ins.uses_rt && (model.rw == ins.rt)));
        stalled = hold || (hazard && !flush);
        stall_q.push_back(stalled);
        if (!hold) begin
            if (flush || hazard) begin
                model.valid = 1'b0;
                model.reg_wr = 1'b0; model.alu_src = 1'b0; model.alu_ctr = 4'd0;
                model.mem_wr = 1'b0; model.mem_to_reg = 1'b0;
                if (!flush && model.bubbles < BUBBLE_MAX) model.bubbles++;
            end else begin
                model.valid = 1'b1;
                model.pc = ins.pc; model.bus_a = ins.bus_a; model.bus_b = ins.bus_b; model.imm = ins.imm;
                model.rs = ins.rs; model.rt = ins.rt;
                model.rw = ins.reg_dst ? ins.rd : ins.rt;
                model.reg_wr = ins.reg_wr; model.alu_src = ins.alu_src; model.alu_ctr = ins.alu_ctr;
                model.mem_wr = ins.mem_wr; model.mem_to_reg = ins.mem_to_reg;
            end
        end
        state_q.push_back(model);
        @(posedge clk);
        #2;
    endtask

    task automatic step(input instr_t ins, input bit hold, input bit flush);
        bit s;
        applyStimulus(ins, hold, flush, s);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock
    task automatic applyReset();
        instr_t z;
        z = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        driveInputs(z, 1'b0, 1'b0);
        #1;
        checkOutput("rst_E_PC", bus.E_PC, 0);
        checkOutput("rst_E_BusA", bus.E_BusA, 0);
        checkOutput("rst_E_BusB", bus.E_BusB, 0);
        checkOutput("rst_E_Imm32", bus.E_Imm32, 0);
        checkOutput("rst_E_regs", {bus.E_Rs, bus.E_Rt, bus.E_Rw}, 0);
        checkOutput("rst_E_ctrl", {bus.E_RegWr, bus.E_ALUSrc, bus.E_MemWr, bus.E_MemToReg, bus.E_ALUCtr}, 0);
        checkOutput("rst_E_Valid", bus.E_Valid, 0);
        checkOutput("rst_Stall", bus.Stall, 0);
        checkOutput("rst_BubbleCnt", bubble_cnt, 0);
        model = '{default: '0};
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Stall monitor: Stall is combinational, sampled mid-cycle
    initial begin
        bit exp_stall;
        forever begin
            @(negedge clk);
            #1;
            if (stall_q.size() > 0) begin
                exp_stall = stall_q.pop_front();
                checkOutput("Stall", bus.Stall, exp_stall);
            end
        end
    end

    // EX monitor: registered outputs sampled just after the edge
    initial begin
        ex_state_t e;
        forever begin
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                checkOutput("E_Valid", bus.E_Valid, e.valid);
                checkOutput("E_ctrl", {bus.E_RegWr, bus.E_ALUSrc, bus.E_MemWr, bus.E_MemToReg, bus.E_ALUCtr},
                            {e.reg_wr, e.alu_src, e.mem_wr, e.mem_to_reg, e.alu_ctr});
                checkOutput("BubbleCnt", bubble_cnt, e.bubbles);
                if (e.valid) begin
                    checkOutput("E_PC", bus.E_PC, e.pc);
                    checkOutput("E_BusA", bus.E_BusA, e.bus_a);
                    checkOutput("E_BusB", bus.E_BusB, e.bus_b);
                    checkOutput("E_Imm32", bus.E_Imm32, e.imm);
                    checkOutput("E_regs", {bus.E_Rs, bus.E_Rt, bus.E_Rw}, {e.rs, e.rt, e.rw});
                end
            end
        end
    end

    initial begin
        instr_t ins;
        bit     stalled;
        rst_n = 1'b1;
        ins = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        driveInputs(ins, 1'b0, 1'b0);
        model = '{default: '0};
        @(posedge clk);
        #2;
        applyReset();

        $display("[TB] load-use on Rs");
        step(lw(5'd8), 1'b0, 1'b0);
        ins = add(5'd8, 5'd3, 5'd10);
        step(ins, 1'b0, 1'b0);
        checkOutput("t2_bubble_valid", bus.E_Valid, 0);
        step(ins, 1'b0, 1'b0);
        checkOutput("t2_add_rw", bus.E_Rw, 10);
        checkOutput("t2_bubbles", bubble_cnt, 1);

        $display("[TB] no-hazard cases");
        step(lw(5'd0), 1'b0, 1'b0);
        step(add(5'd0, 5'd0, 5'd6), 1'b0, 1'b0);
        step(lw(5'd9), 1'b0, 1'b0);
        step(ori(5'd2, 5'd9), 1'b0, 1'b0);
        checkOutput("t3_ori_valid", bus.E_Valid, 1);
        checkOutput("t3_bubbles", bubble_cnt, 1);

        $display("[TB] flush");
        step(lw(5'd8), 1'b0, 1'b0);
        step(add(5'd8, 5'd8, 5'd11), 1'b0, 1'b1);
        checkOutput("t4_flush_valid", bus.E_Valid, 0);
        checkOutput("t4_bubbles", bubble_cnt, 1);
        step(add(5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
        checkOutput("t4_flush_only_valid", bus.E_Valid, 0);

        $display("[TB] hold during load-use");
        step(lw(5'd8), 1'b0, 1'b0);
        ins = add(5'd4, 5'd8, 5'd12);
        for (int i = 0; i < 3; i++) begin
            step(ins, 1'b1, 1'b0);
            checkOutput("t5_frozen_rw", bus.E_Rw, 8);
            checkOutput("t5_frozen_bubbles", bubble_cnt, 1);
        end
        step(ins, 1'b0, 1'b0);
        checkOutput("t5_bubbles", bubble_cnt, 2);
        step(ins, 1'b0, 1'b0);
        checkOutput("t5_add_rw", bus.E_Rw, 12);

        $display("[TB] counter saturation");
        applyReset();
        for (int i = 0; i < 5; i++) begin
            step(lw(5'd8), 1'b0, 1'b0);
            ins = add(5'd8, 5'd1, 5'd13);
            step(ins, 1'b0, 1'b0);
            step(ins, 1'b0, 1'b0);
            if (i == 2) checkOutput("t6_third", bubble_cnt, 3);
        end
        checkOutput("t6_saturated", bubble_cnt, 3);

        $display("[TB] random stream");
        applyReset();
        stalled = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                applyReset();
                stalled = 1'b0;
            end
            if (!stalled) ins = rand_instr();
            applyStimulus(ins, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10), stalled);
        end

        applyReset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
